// File: rtl/fetch_unit.sv
// Instruction fetch: requests 32-bit words, splits them into 16-bit instructions, queues them for the decoder.
// Latency: a fetched word is visible at instr_out the cycle after mem_output_valid_in (empty FIFO).
// Backpressure: requests stall while stall_mem2fetch_in is high; fetching pauses when fewer than 2 slots are free.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-low reset
//   fetch_load_out/addr     word fetch request to the memory controller (held until accepted)
//   stall_mem2fetch_in      controller cannot accept the request this cycle
//   mem_output_valid_in     read data valid, mem_data_in holds the requested word
//   branch_valid_in/target  redirect pulse: flush FIFO, drop in-flight fetch, restart at target
//   decoder_ready_in        decoder consumes the head instruction this cycle
//   instr_valid_out/instr_out/instr_pc_out  FIFO head and its byte address
module fetch_unit #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic                fetch_load_out,
    output logic [PC_WIDTH-1:0] fetch_addr_out,
    input  logic                stall_mem2fetch_in,
    input  logic                mem_output_valid_in,
    input  logic [31:0]         mem_data_in,
    input  logic                branch_valid_in,
    input  logic [PC_WIDTH-1:0] branch_target_in,
    input  logic                decoder_ready_in,
    output logic                instr_valid_out,
    output logic [15:0]         instr_out,
    output logic [PC_WIDTH-1:0] instr_pc_out
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DROP} state_t;

    localparam logic [PC_WIDTH-1:0] PC_HALF = PC_WIDTH'(2);
    localparam logic [PC_WIDTH-1:0] PC_WORD = PC_WIDTH'(4);

    state_t              state;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] head_pc;
    logic [15:0]         fifo_mem [4];
    logic [1:0]          rd_ptr;
    logic [1:0]          wr_ptr;
    logic [2:0]          count;

    logic                pop;
    logic                accept;
    logic                rsp;
    logic [2:0]          n_push;
    logic [2:0]          count_after_pop;
    logic [2:0]          count_next;
    logic [PC_WIDTH-1:0] word_pc;
    logic [PC_WIDTH-1:0] target_pc;

    always_comb begin
        word_pc         = {fetch_pc[PC_WIDTH-1:2], 2'b00};
        target_pc       = {branch_target_in[PC_WIDTH-1:1], 1'b0};
        // a redirect wins over everything: no pop, no push this cycle
        pop             = (count != 3'd0) && decoder_ready_in && !branch_valid_in;
        accept          = (state == ST_REQ) && !stall_mem2fetch_in;
        rsp             = (state == ST_WAIT) && mem_output_valid_in && !branch_valid_in;
        // an odd-halfword PC only wants the upper half of the word
        n_push          = rsp ? (fetch_pc[1] ? 3'd1 : 3'd2) : 3'd0;
        count_after_pop = count - {2'b00, pop};
        count_next      = count_after_pop + n_push;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            head_pc  <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
        end else if (branch_valid_in) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fetch_pc <= target_pc;
            head_pc  <= target_pc;
            case (state)
                ST_IDLE: state <= ST_REQ;
                // if accepted now, its response is still to come and must be dropped
                ST_REQ:  state <= accept ? ST_DROP : ST_REQ;
                // data arriving together with the redirect is stale and simply ignored
                ST_WAIT: state <= mem_output_valid_in ? ST_REQ : ST_DROP;
                // the awaited stale response may land in this very cycle; waiting on
                // for another one would never end
                ST_DROP: state <= mem_output_valid_in ? ST_REQ : ST_DROP;
                default: state <= ST_IDLE;
            endcase
        end else begin
            if (pop) begin
                rd_ptr  <= rd_ptr + 2'd1;
                head_pc <= head_pc + PC_HALF;
            end
            if (rsp) begin
                if (!fetch_pc[1]) begin
                    fifo_mem[wr_ptr]        <= mem_data_in[15:0];
                    fifo_mem[wr_ptr + 2'd1] <= mem_data_in[31:16];
                    wr_ptr                  <= wr_ptr + 2'd2;
                end else begin
                    fifo_mem[wr_ptr] <= mem_data_in[31:16];
                    wr_ptr           <= wr_ptr + 2'd1;
                end
                fetch_pc <= word_pc + PC_WORD;
            end
            count <= count_next;
            case (state)
                // at least two free slots so a full word always fits
                ST_IDLE: if (count_after_pop <= 3'd2) state <= ST_REQ;
                ST_REQ:  if (accept) state <= ST_WAIT;
                ST_WAIT: if (rsp) state <= (count_next <= 3'd2) ? ST_REQ : ST_IDLE;
                ST_DROP: if (mem_output_valid_in) state <= ST_REQ;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign fetch_load_out  = (state == ST_REQ);
    assign fetch_addr_out  = word_pc;
    assign instr_valid_out = (count != 3'd0);
    assign instr_out       = instr_valid_out ? fifo_mem[rd_ptr] : 16'h0000;
    assign instr_pc_out    = head_pc;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          fetch_load_out;
    logic [W-1:0]  fetch_addr;
    logic          stall;
    logic          mem_valid;
    logic [31:0]   mem_data;
    logic          branch_valid;
    logic [W-1:0]  branch_target;
    logic          decoder_ready;
    logic          instr_valid;
    logic [15:0]   instr;
    logic [W-1:0]  instr_pc;

    always #5 clk = ~clk;

    fetch_unit #(.PC_WIDTH(W), .RESET_PC('0)) dut (
        .clk                 (clk),
        .reset               (reset),
        .fetch_load_out      (fetch_load_out),
        .fetch_addr_out      (fetch_addr),
        .stall_mem2fetch_in  (stall),
        .mem_output_valid_in (mem_valid),
        .mem_data_in         (mem_data),
        .branch_valid_in     (branch_valid),
        .branch_target_in    (branch_target),
        .decoder_ready_in    (decoder_ready),
        .instr_valid_out     (instr_valid),
        .instr_out           (instr),
        .instr_pc_out        (instr_pc)
    );

    int           n_vec  = 0;
    int           n_fail = 0;
    int           resp_cnt;
    int           lat;
    logic [W-1:0] resp_addr;
    logic [W-1:0] exp_pc;
    logic [W-1:0] exp_fetch;
    logic [W-1:0] acc_q[$];
    logic [15:0]  pop_i[$];
    logic [W-1:0] pop_pc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory image: two fixed words at 0 and 4, elsewhere halfword at byte p is F000^p.
    function automatic logic [31:0] word_at(input logic [W-1:0] a);
        logic [15:0] lo;
        logic [15:0] hi;
        if (a == 32'h0) return 32'hBBBB_AAAA;
        if (a == 32'h4) return 32'hDDDD_CCCC;
        lo = a[15:0];
        hi = lo + 16'd2;
        return {16'hF000 ^ hi, 16'hF000 ^ lo};
    endfunction

    function automatic logic [15:0] half_at(input logic [W-1:0] p);
        logic [31:0] w;
        w = word_at({p[W-1:2], 2'b00});
        return p[1] ? w[31:16] : w[15:0];
    endfunction

    // One clock: drive the memory responder, let the edge happen, then update the
    // reference model from the pre-edge events and compare the DUT against it.
    task automatic step();
        logic         acc, pop, br;
        logic [W-1:0] tgt, ppc, faddr;
        logic [15:0]  pi;
        mem_valid = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                mem_valid = 1'b1;
                mem_data  = word_at(resp_addr);
            end
        end
        acc   = fetch_load_out && !stall;
        pop   = instr_valid && decoder_ready && !branch_valid;
        br    = branch_valid;
        tgt   = branch_target;
        pi    = instr;
        ppc   = instr_pc;
        faddr = fetch_addr;
        @(posedge clk);
        #1;
        branch_valid = 1'b0;
        if (acc) begin
            check("one_outstanding", resp_cnt, 0);
            check("fetch_addr", faddr, exp_fetch);
            acc_q.push_back(faddr);
            exp_fetch = exp_fetch + 4;
            resp_cnt  = lat;
            resp_addr = faddr;
        end
        if (pop) begin
            pop_i.push_back(pi);
            pop_pc.push_back(ppc);
        end
        if (br) begin
            exp_pc    = {tgt[W-1:1], 1'b0};
            exp_fetch = {tgt[W-1:2], 2'b00};
            check("flush_valid", instr_valid, 0);
        end else if (pop) begin
            exp_pc = exp_pc + 2;
        end
        if (instr_valid) begin
            check("head_pc", instr_pc, exp_pc);
            check("head_instr", instr, half_at(instr_pc));
        end
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        stall         = 1'b0;
        mem_valid     = 1'b0;
        mem_data      = '0;
        branch_valid  = 1'b0;
        branch_target = '0;
        decoder_ready = 1'b0;
        resp_cnt      = 0;
        lat           = 1;
        exp_pc        = '0;
        exp_fetch     = '0;
        acc_q.delete();
        pop_i.delete();
        pop_pc.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int  n0;
        bit  ok;
        logic [W-1:0] hold;

        // reset state
        reset = 1'b0; stall = 1'b0; mem_valid = 1'b0; mem_data = '0;
        branch_valid = 1'b0; branch_target = '0; decoder_ready = 1'b0;
        #1;
        check("rst_load", fetch_load_out, 0);
        check("rst_addr", fetch_addr, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_pc", instr_pc, 0);

        // 1: straight-line fetch from reset
        do_reset();
        decoder_ready = 1'b1;
        repeat (12) step();
        check("t1_acc0", acc_q[0], 32'h0);
        check("t1_acc1", acc_q[1], 32'h4);
        check("t1_i0", pop_i[0], 16'hAAAA); check("t1_p0", pop_pc[0], 32'h0);
        check("t1_i1", pop_i[1], 16'hBBBB); check("t1_p1", pop_pc[1], 32'h2);
        check("t1_i2", pop_i[2], 16'hCCCC); check("t1_p2", pop_pc[2], 32'h4);
        check("t1_i3", pop_i[3], 16'hDDDD); check("t1_p3", pop_pc[3], 32'h6);

        // 2: long stall holds the request stable
        do_reset();
        stall = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            step();
            ok = fetch_load_out;
        end
        check("t2_req_seen", ok, 1);
        hold = fetch_addr;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_load_held", fetch_load_out, 1);
            check("t2_addr_held", fetch_addr, hold);
        end
        check("t2_no_acc", acc_q.size(), 0);
        stall = 1'b0;
        step();
        check("t2_one_acc", acc_q.size(), 1);
        check("t2_load_drop", fetch_load_out, 0);

        // 3: full FIFO parks in IDLE; refetch only once two slots are free
        do_reset();
        repeat (10) step();
        check("t3_acc", acc_q.size(), 2);
        check("t3_idle", fetch_load_out, 0);
        check("t3_valid", instr_valid, 1);
        decoder_ready = 1'b1; step(); decoder_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_still_idle", fetch_load_out, 0);
        end
        decoder_ready = 1'b1; step(); decoder_ready = 1'b0;
        check("t3_req", fetch_load_out, 1);
        check("t3_req_addr", fetch_addr, 32'h8);

        // 4: redirect during WAIT, stale word must be dropped
        do_reset();
        lat = 3;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            step();
            ok = (acc_q.size() == 1);
        end
        check("t4_acc_seen", ok, 1);
        branch_valid = 1'b1; branch_target = 32'h102;
        step();
        decoder_ready = 1'b1;
        repeat (16) step();
        check("t4_acc1", acc_q[1], 32'h100);
        check("t4_i0", pop_i[0], 16'hF102); check("t4_p0", pop_pc[0], 32'h102);
        check("t4_i1", pop_i[1], 16'hF104); check("t4_p1", pop_pc[1], 32'h104);

        // 5: redirect coinciding with a response and a pop
        do_reset();
        decoder_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            ok = (resp_cnt == 1) && instr_valid && (acc_q.size() >= 2);
        end
        check("t5_setup", ok, 1);
        n0 = pop_i.size();
        branch_valid = 1'b1; branch_target = 32'h200;
        step();
        check("t5_no_pop", pop_i.size(), n0);
        check("t5_empty", instr_valid, 0);
        check("t5_req", fetch_load_out, 1);
        check("t5_addr", fetch_addr, 32'h200);
        repeat (8) step();
        check("t5_i0", pop_i[n0], 16'hF200); check("t5_p0", pop_pc[n0], 32'h200);

        // 6: reset during WAIT with a populated FIFO
        do_reset();
        lat = 3;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            step();
            ok = (acc_q.size() == 2);
        end
        check("t6_setup", ok, 1);
        check("t6_prefill", instr_valid, 1);
        reset = 1'b0;
        #1;
        check("t6_load", fetch_load_out, 0);
        check("t6_addr", fetch_addr, 0);
        check("t6_valid", instr_valid, 0);
        check("t6_instr", instr, 0);
        check("t6_pc", instr_pc, 0);
        do_reset();
        decoder_ready = 1'b1;
        repeat (8) step();
        check("t6_acc0", acc_q[0], 32'h0);
        check("t6_i0", pop_i[0], 16'hAAAA); check("t6_p0", pop_pc[0], 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the memory controller.
- Issues word fetch requests to the controller via fetch_load_out and retries while stall_mem2fetch_in is high.
- Receives 32-bit words from memory, splits them into 16-bit instructions and buffers them in a 4-entry halfword FIFO.
- Presents instructions with their PC to the decoder over a valid/ready handshake; a branch redirect flushes the FIFO and discards any in-flight fetch.

Parameters:
PC_WIDTH, 32, width of PC / fetch address (byte address)
RESET_PC, 0, PC loaded at reset (halfword aligned)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
fetch_load_out  out  1  fetch request to memory controller
fetch_addr_out  out  PC_WIDTH  word-aligned fetch address (bits[1:0]=0)
stall_mem2fetch_in  in  1  controller busy; request not accepted this cycle
mem_output_valid_in  in  1  memory read data valid
mem_data_in  in  32  memory read data
branch_valid_in  in  1  redirect request (1-cycle pulse)
branch_target_in  in  PC_WIDTH  redirect target; bit0 ignored
decoder_ready_in  in  1  decoder consumes instr_out this cycle
instr_valid_out  out  1  FIFO head valid
instr_out  out  16  FIFO head instruction
instr_pc_out  out  PC_WIDTH  byte address of instr_out

Behaviour:
- Reset (asynchronous, while reset=0):
  - fetch_pc=RESET_PC, head_pc=RESET_PC, FIFO empty (count=0), state=IDLE.
  - All outputs 0; fetch_addr_out = RESET_PC with bits[1:0]=0.
- FSM states: IDLE, REQ, WAIT, DROP.
  - IDLE: fetch_load_out=0. Go to REQ when free slots (4-count) >= 2, evaluated after this cycle's pop.
  - REQ: fetch_load_out=1 and fetch_addr_out={fetch_pc[PC_WIDTH-1:2],2'b00}, both held stable until accepted.
    - Accepted in a cycle with fetch_load_out=1 and stall_mem2fetch_in=0; then go to WAIT.
    - Stall high: remain in REQ. No limit on stall length.
  - WAIT: fetch_load_out=0. On mem_output_valid_in=1, write the word into the FIFO.
    - fetch_pc[1]=0: push mem_data_in[15:0] (pc), then [31:16] (pc+2).
    - fetch_pc[1]=1: push only [31:16].
    - Then fetch_pc = word address + 4. Go to REQ if post-push free >= 2, else IDLE.
  - DROP: fetch_load_out=0. Wait for the stale mem_output_valid_in, discard the data, then go to REQ.
- Memory response arrives no earlier than the cycle after acceptance. At most one outstanding request.
- FIFO rules:
  - instr_valid_out = (count != 0); instr_out = head entry; instr_pc_out = head_pc.
  - Pop when instr_valid_out && decoder_ready_in; head_pc += 2.
  - Push and pop in the same cycle are allowed; count changes by pushes - pops.
  - Overflow cannot occur: a request is issued only with free >= 2.
  - decoder_ready_in with empty FIFO has no effect.
- Branch (branch_valid_in=1) takes priority over push and pop. Next cycle:
  - FIFO empty; fetch_pc = head_pc = {target[PC_WIDTH-1:1],1'b0}; instr_valid_out=0.
  - Next state by current state and same-cycle events:
    - IDLE: go to REQ.
    - REQ not accepted this cycle: stay in REQ; the new address appears next cycle.
    - REQ accepted this cycle: go to DROP.
    - WAIT without mem_output_valid_in: go to DROP.
    - WAIT with mem_output_valid_in: discard the data, go to REQ.
    - DROP: stay in DROP.
- PC arithmetic wraps modulo 2^PC_WIDTH.
- Asserting reset mid-operation aborts everything immediately. Any later response from a pre-reset request is a system-level error and out of scope.

Test Plan:
1. Reset release with RESET_PC=0, no stall, 1-cycle memory latency, data 0xBBBBAAAA then 0xDDDDCCCC -> fetch_addr 0x0, 0x4; instr/pc sequence AAAA@0, BBBB@2, CCCC@4, DDDD@6.
2. Hold stall_mem2fetch_in=1 for 5 cycles during REQ -> fetch_load_out stays 1 and fetch_addr_out stays stable; exactly one acceptance when stall drops.
3. decoder_ready_in=0 throughout -> after two words the FIFO holds 4 entries, state is IDLE, fetch_load_out=0. Pop one -> stays IDLE; pop second -> REQ next cycle.
4. Branch to 0x102 while in WAIT, then stale data arrives -> stale word discarded; next fetch_addr 0x100; first instruction is data[31:16] with pc 0x102, followed by pc 0x104.
5. Branch coinciding with mem_output_valid_in and decoder pop -> data not pushed, no pop counted, instr_valid_out=0 next cycle, REQ to the target word.
6. Assert reset during WAIT -> all outputs 0 immediately; after release, fetch restarts at RESET_PC.
